light_sequencer: RTL

- Output stage directly downstream of the one-hot direction-select state machine.
- Consumes the machine's registered 5-bit one-hot present state and drives two 3-lamp banks (left, right) with timed patterns.
- Left modes: sequential sweep and all-blink. Right modes: the same pair.
- Built-in prescaler sets the pattern step rate; no combinational path from the state input to the lamp outputs.

---
 rtl/light_sequencer_if.sv | 48 ++++
 rtl/light_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/light_sequencer_if.sv
// Link between the direction-select FSM and the lamp output stage.
// The hazard input exists only when LIGHT_SEQUENCER_HAZARD_EN is defined.
interface light_sequencer_if;
    logic [4:0] state;
`ifdef LIGHT_SEQUENCER_HAZARD_EN
    logic       hazard;
`endif
    logic [2:0] lamp_l;
    logic [2:0] lamp_r;
    logic       tick;
    logic       state_err;

`ifdef LIGHT_SEQUENCER_HAZARD_EN
    modport master (
        output state,
        output hazard,
        input  lamp_l,
        input  lamp_r,
        input  tick,
        input  state_err
    );

    modport slave (
        input  state,
        input  hazard,
        output lamp_l,
        output lamp_r,
        output tick,
        output state_err
    );
`else
    modport master (
        output state,
        input  lamp_l,
        input  lamp_r,
        input  tick,
        input  state_err
    );

    modport slave (
        input  state,
        output lamp_l,
        output lamp_r,
        output tick,
        output state_err
    );
`endif
endinterface

// File: rtl/light_sequencer.sv
// Lamp pattern stage: latches the one-hot selector state and drives timed sweep/blink patterns.
// Optional hazard override is compiled in with LIGHT_SEQUENCER_HAZARD_EN.
module light_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    light_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    localparam logic [4:0] MODE_L_SWEEP = 5'b00010;
    localparam logic [4:0] MODE_L_BLINK = 5'b00100;
    localparam logic [4:0] MODE_R_SWEEP = 5'b01000;
    localparam logic [4:0] MODE_R_BLINK = 5'b10000;

    logic [4:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    // Distinguishes the cleared reset value of mode_q from a latched all-zero state.
    logic             seen_q;

    logic             haz;
    logic             haz_changed;
    logic             mode_onehot;
    logic             mode_active;
    logic             run;
    logic             at_max;
    logic             changed;
    logic [2:0]       sweep_pat;
    logic [2:0]       blink_pat;

`ifdef LIGHT_SEQUENCER_HAZARD_EN
    logic haz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            haz_q <= 1'b0;
        end else begin
            haz_q <= bus.hazard;
        end
    end

    assign haz         = haz_q;
    assign haz_changed = (bus.hazard != haz_q);
`else
    assign haz         = 1'b0;
    assign haz_changed = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seen_q  <= 1'b1;
        end
    end

    always_comb begin
        mode_onehot = (mode_q != 5'd0) && ((mode_q & (mode_q - 5'd1)) == 5'd0);
        mode_active = mode_onehot && !mode_q[0];
        run         = mode_active || haz;
        at_max      = (cnt_q == CNT_MAX);
        changed     = (bus.state != mode_q) || haz_changed;
    end

    // Any input change restarts the pattern; idle/invalid modes park the counters at zero.
    always_comb begin
        mode_d  = bus.state;
        cnt_d   = '0;
        phase_d = '0;
        if (!changed && run) begin
            if (at_max) begin
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                phase_d = phase_q;
            end
        end
    end

    always_comb begin
        sweep_pat = 3'b000;
        case (phase_q)
            2'd0:    sweep_pat = 3'b001;
            2'd1:    sweep_pat = 3'b011;
            2'd2:    sweep_pat = 3'b111;
            default: sweep_pat = 3'b000;
        endcase
        blink_pat = phase_q[0] ? 3'b000 : 3'b111;
    end

    always_comb begin
        bus.lamp_l    = 3'b000;
        bus.lamp_r    = 3'b000;
        bus.tick      = run && at_max;
        bus.state_err = seen_q && !mode_onehot;
        if (haz) begin
            bus.lamp_l = blink_pat;
            bus.lamp_r = blink_pat;
        end else begin
            case (mode_q)
                MODE_L_SWEEP: bus.lamp_l = sweep_pat;
                MODE_L_BLINK: bus.lamp_l = blink_pat;
                MODE_R_SWEEP: bus.lamp_r = sweep_pat;
                MODE_R_BLINK: bus.lamp_r = blink_pat;
                default: ;
            endcase
        end
    end

endmodule
